// File: rtl/cfg_sequencer_if.sv
// Bundle of the sequencer's start/status, ROM read and I2C byte-request signals.
// The "master" modport is the sequencer side; "slave" is the ROM/byte-master side.
interface cfg_sequencer_if #(
    parameter int AW         = 9,
    parameter int MEM_WIDTH  = 24,
    parameter int DATA_WIDTH = 8
);
    logic                  start_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  err_o;
    logic [AW-1:0]         err_idx_o;
    logic [AW-1:0]         rom_addr_o;
    logic [MEM_WIDTH-1:0]  rom_data_i;
    logic                  i2c_valid_o;
    logic                  i2c_ready_i;
    logic [DATA_WIDTH-1:0] i2c_data_o;
    logic                  i2c_start_o;
    logic                  i2c_stop_o;
    logic                  i2c_done_i;
    logic                  i2c_nack_i;

    modport master (
        input  start_i, rom_data_i, i2c_ready_i, i2c_done_i, i2c_nack_i,
        output busy_o, done_o, err_o, err_idx_o, rom_addr_o,
               i2c_valid_o, i2c_data_o, i2c_start_o, i2c_stop_o
    );

    modport slave (
        output start_i, rom_data_i, i2c_ready_i, i2c_done_i, i2c_nack_i,
        input  busy_o, done_o, err_o, err_idx_o, rom_addr_o,
               i2c_valid_o, i2c_data_o, i2c_start_o, i2c_stop_o
    );
endinterface

// File: rtl/cfg_sequencer.sv
// Walks a config ROM and writes every {reg_hi, reg_lo, value} entry to the Si5340 as a
// 4-byte I2C write, inserting a long settle pause after the preamble entries.
module cfg_sequencer #(
    parameter int         MEM_DEPTH    = 326,
    parameter int         MEM_WIDTH    = 24,
    parameter int         DATA_WIDTH   = 8,
    parameter logic [6:0] SLAVE_ADDR   = 7'h74,
    parameter int         PAUSE_IDX    = 2,
    parameter int         PAUSE_CYCLES = 37_500_000,
    localparam int        AW           = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    cfg_sequencer_if.master   bus
);

    localparam logic [AW-1:0] LAST_IDX   = AW'(MEM_DEPTH - 1);
    localparam logic [AW-1:0] PAUSE_AT   = AW'(PAUSE_IDX);
    localparam logic [31:0]   PAUSE_LAST = (PAUSE_CYCLES > 1) ? 32'(PAUSE_CYCLES - 1) : 32'd0;

    typedef enum logic [2:0] {
        IDLE, FETCH, LATCH, SEND, WAIT_ACK, PAUSE, DONE, ERROR
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [AW-1:0]        index;
    logic [1:0]           byte_cnt;
    logic [31:0]          pause_cnt;
    logic [MEM_WIDTH-1:0] word;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERROR: if (bus.start_i) state_next = FETCH;
            FETCH:             state_next = LATCH;
            LATCH:             state_next = SEND;
            SEND:              if (bus.i2c_ready_i) state_next = WAIT_ACK;
            WAIT_ACK: begin
                if (bus.i2c_done_i) begin
                    if (bus.i2c_nack_i)          state_next = ERROR;
                    else if (byte_cnt != 2'd3)   state_next = SEND;
                    else if (index == LAST_IDX)  state_next = DONE;
                    else if (index == PAUSE_AT)  state_next = PAUSE;
                    else                         state_next = FETCH;
                end
            end
            PAUSE:             if (pause_cnt >= PAUSE_LAST) state_next = FETCH;
            default:           state_next = IDLE;
        endcase
    end

    // Datapath follows the chosen transition so index/byte bookkeeping cannot disagree with the FSM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            index     <= '0;
            byte_cnt  <= '0;
            pause_cnt <= '0;
            word      <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (state_next == FETCH) begin
                        index    <= '0;
                        byte_cnt <= '0;
                    end
                end
                LATCH: begin
                    word     <= bus.rom_data_i;
                    byte_cnt <= '0;
                end
                WAIT_ACK: begin
                    if (state_next == SEND)  byte_cnt  <= byte_cnt + 2'd1;
                    if (state_next == FETCH) index     <= index + AW'(1);
                    if (state_next == PAUSE) pause_cnt <= '0;
                end
                PAUSE: begin
                    if (state_next == FETCH)   index     <= index + AW'(1);
                    else if (pause_cnt != '1)  pause_cnt <= pause_cnt + 32'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy_o      = 1'b0;
        bus.done_o      = 1'b0;
        bus.err_o       = 1'b0;
        bus.err_idx_o   = '0;
        bus.rom_addr_o  = index;
        bus.i2c_valid_o = 1'b0;
        bus.i2c_data_o  = '0;
        bus.i2c_start_o = 1'b0;
        bus.i2c_stop_o  = 1'b0;
        case (state)
            FETCH, LATCH, WAIT_ACK, PAUSE: bus.busy_o = 1'b1;
            SEND: begin
                bus.busy_o      = 1'b1;
                bus.i2c_valid_o = 1'b1;
                bus.i2c_start_o = (byte_cnt == 2'd0);
                bus.i2c_stop_o  = (byte_cnt == 2'd3);
                case (byte_cnt)
                    2'd0:    bus.i2c_data_o = DATA_WIDTH'({SLAVE_ADDR, 1'b0});
                    2'd1:    bus.i2c_data_o = DATA_WIDTH'(word[23:16]);
                    2'd2:    bus.i2c_data_o = DATA_WIDTH'(word[15:8]);
                    default: bus.i2c_data_o = DATA_WIDTH'(word[7:0]);
                endcase
            end
            DONE:  bus.done_o = 1'b1;
            ERROR: begin
                bus.err_o     = 1'b1;
                bus.err_idx_o = index;
            end
            default: ;
        endcase
    end

endmodule
